// File: rtl/sha256_serial_pkg.sv
// rtl/sha256_serial_pkg.sv - shared state encoding and constants for the digest serializer
package sha256_serial_pkg;

  localparam int DIGEST_BYTES_DEFAULT = 32;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DRAIN
  } state_t;

endpackage

// File: rtl/sha256_digest_serializer_if.sv
// rtl/sha256_digest_serializer_if.sv - digest input, UART handshake and status signals
interface sha256_digest_serializer_if
  import sha256_serial_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEFAULT
);

  logic [8*DIGEST_BYTES-1:0] digest_in;
  logic                      digest_valid;
  logic                      tx_busy;
  logic                      tx_start;
  logic [7:0]                tx_data;
  logic                      busy;
  logic                      done;
  logic                      overrun;

  modport master (
    input  digest_in, digest_valid, tx_busy,
    output tx_start, tx_data, busy, done, overrun
  );

  modport slave (
    output digest_in, digest_valid, tx_busy,
    input  tx_start, tx_data, busy, done, overrun
  );

endinterface

// File: rtl/sha256_hex_nibble.sv
// rtl/sha256_hex_nibble.sv - nibble to lowercase ASCII hex, used when SHA256_SERIAL_HEX_ASCII_EN is set
module sha256_hex_nibble (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = 8'h30 + {4'h0, nibble_i};
    else                  ascii_o = 8'h57 + {4'h0, nibble_i};
  end

endmodule

// File: rtl/sha256_digest_serializer.sv
// rtl/sha256_digest_serializer.sv - streams a captured digest to a UART one character at a time
// SHA256_SERIAL_HEX_ASCII_EN: send lowercase hex pairs plus CR LF instead of raw bytes.
module sha256_digest_serializer
  import sha256_serial_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEFAULT
) (
  input logic clk,
  input logic rst,
  sha256_digest_serializer_if.master bus
);

  localparam int DW = 8 * DIGEST_BYTES;
`ifdef SHA256_SERIAL_HEX_ASCII_EN
  localparam int FRAME_CHARS = 2 * DIGEST_BYTES + 2;
`else
  localparam int FRAME_CHARS = DIGEST_BYTES;
`endif
  localparam int IDX_W = $clog2(FRAME_CHARS + 1);
  localparam logic [IDX_W-1:0] FRAME_END = IDX_W'(FRAME_CHARS);

  state_t           state_q, state_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic [7:0]       cur_char;
  logic             byte_done;

`ifdef SHA256_SERIAL_HEX_ASCII_EN
  localparam logic [IDX_W-1:0] CR_IDX = IDX_W'(2 * DIGEST_BYTES);
  logic [3:0] nibble;
  logic [7:0] hex_char;

  // Even index sends the high nibble; the byte is shifted out after its low nibble.
  assign nibble    = idx_q[0] ? shift_q[DW-5 -: 4] : shift_q[DW-1 -: 4];
  assign byte_done = idx_q[0];

  sha256_hex_nibble u_hex_nibble (
    .nibble_i (nibble),
    .ascii_o  (hex_char)
  );

  always_comb begin
    cur_char = hex_char;
    if (idx_q == CR_IDX)     cur_char = ASCII_CR;
    else if (idx_q > CR_IDX) cur_char = ASCII_LF;
  end
`else
  assign cur_char  = shift_q[DW-1 -: 8];
  assign byte_done = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        // The done cycle still belongs to the finished frame, so a digest there is refused.
        if (bus.digest_valid) begin
          if (done_q) begin
            overrun_d = 1'b1;
          end else begin
            shift_d   = bus.digest_in;
            idx_d     = '0;
            overrun_d = 1'b0;
            state_d   = SEND;
          end
        end
      end
      SEND: begin
        if (bus.digest_valid) overrun_d = 1'b1;
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_char;
          idx_d      = idx_q + IDX_W'(1);
          if (byte_done) shift_d = shift_q << 8;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (bus.digest_valid) overrun_d = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.digest_valid) overrun_d = 1'b1;
        if (!bus.tx_busy) begin
          if (idx_q == FRAME_END) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// tb/tb_sha256_digest_serializer.sv - directed bench for the digest serializer with a 10-cycle UART model
module tb_sha256_digest_serializer;
  import sha256_serial_pkg::*;

  localparam int DB = 32;
`ifdef SHA256_SERIAL_HEX_ASCII_EN
  localparam int FRAME = 2 * DB + 2;
`else
  localparam int FRAME = DB;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_digest_serializer_if #(.DIGEST_BYTES(DB)) bus ();

  sha256_digest_serializer #(.DIGEST_BYTES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // UART model: busy for 10 cycles starting the cycle after tx_start, plus a manual stall.
  int   busy_cnt  = 0;
  logic hold_busy = 1'b0;
  assign bus.tx_busy = (busy_cnt != 0) || hold_busy;
  always @(posedge clk) begin
    if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
    else if (bus.tx_start) busy_cnt <= 10;
  end

  logic [7:0] chars[$];
  int   done_cnt   = 0;
  int   prot_err   = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (bus.tx_start) begin
      if (prev_start || bus.tx_busy) prot_err <= prot_err + 1;
      chars.push_back(bus.tx_data);
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    prev_start <= bus.tx_start;
  end

  logic [255:0] abc_digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [7:0]   exp_frame[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] char_at(input int i);
    if (i < chars.size()) return {8'h00, chars[i]};
    return 16'hffff;
  endfunction

  task automatic send_digest(input logic [255:0] d);
    @(negedge clk);
    bus.digest_in    = d;
    bus.digest_valid = 1'b1;
    @(negedge clk);
    bus.digest_valid = 1'b0;
  endtask

  task automatic wait_chars(input int n, input string tag);
    for (int k = 0; k < 3000 && chars.size() < n; k++) begin
      @(negedge clk);
      #1;
    end
    check(tag, 32'(chars.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int k = 0; k < 3000 && done_cnt < target; k++) begin
      @(negedge clk);
      #1;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_frame(input int base, input string tag);
    int mism = 0;
    check({tag, "_len"}, 32'(chars.size() - base), 32'(FRAME));
    for (int i = 0; i < FRAME; i++)
      if (char_at(base + i) !== {8'h00, exp_frame[i]}) mism++;
    check({tag, "_data"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int base;
    int lat;
    string hexs = "0123456789abcdef";
    logic [7:0] b;

    for (int i = 0; i < DB; i++) begin
      b = abc_digest[255 - 8*i -: 8];
`ifdef SHA256_SERIAL_HEX_ASCII_EN
      exp_frame.push_back(hexs[b[7:4]]);
      exp_frame.push_back(hexs[b[3:0]]);
`else
      exp_frame.push_back(b);
`endif
    end
`ifdef SHA256_SERIAL_HEX_ASCII_EN
    exp_frame.push_back(8'h0D);
    exp_frame.push_back(8'h0A);
`endif

    bus.digest_in    = '0;
    bus.digest_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1 with latency check: tx_start lands in the second cycle after capture.
    base = chars.size();
    send_digest(abc_digest);
    check("lat_first_cycle", 32'(bus.tx_start), 32'd0);
    check("busy_after_capture", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("lat_second_cycle", 32'(bus.tx_start), 32'd1);
    wait_done(1, "f1_done_timeout");
    check_frame(base, "f1");
    check("f1_done_busy_low", 32'(bus.busy), 32'd0);
`ifdef SHA256_SERIAL_HEX_ASCII_EN
    check("f1_char1", 32'(char_at(base + 0)), 32'h62);
    check("f1_char2", 32'(char_at(base + 1)), 32'h61);
    check("f1_char64", 32'(char_at(base + 63)), 32'h64);
    check("f1_char65", 32'(char_at(base + 64)), 32'h0D);
    check("f1_char66", 32'(char_at(base + 65)), 32'h0A);
`else
    check("f1_first", 32'(char_at(base + 0)), 32'hBA);
    check("f1_last", 32'(char_at(base + 31)), 32'hAD);
`endif

    // Digest one cycle after done is accepted.
    base = chars.size();
    send_digest(abc_digest);
    check("back2back_busy", 32'(bus.busy), 32'd1);
    wait_done(2, "f2_done_timeout");
    check_frame(base, "f2");
    check("f2_overrun", 32'(bus.overrun), 32'd0);

    // Digest in the done cycle itself is refused.
    base = chars.size();
    bus.digest_valid = 1'b1;
    @(negedge clk);
    bus.digest_valid = 1'b0;
    #1;
    check("done_collide_overrun", 32'(bus.overrun), 32'd1);
    check("done_collide_busy", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check("done_collide_no_tx", 32'(chars.size() - base), 32'd0);

    // Mid-frame digest sets overrun without disturbing the stream.
    base = chars.size();
    send_digest(abc_digest);
    check("overrun_cleared", 32'(bus.overrun), 32'd0);
    wait_chars(base + 3, "ovr_chars_timeout");
    send_digest('0);
    check("overrun_set", 32'(bus.overrun), 32'd1);
    wait_done(3, "ovr_done_timeout");
    check_frame(base, "ovr");
    check("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Stall tx_busy after the first char.
    base = chars.size();
    send_digest(abc_digest);
    wait_chars(base + 1, "hold_first_timeout");
    hold_busy = 1'b1;
    repeat (500) @(negedge clk);
    #1;
    check("hold_no_tx", 32'(chars.size() - base), 32'd1);
    hold_busy = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      #1;
      if (chars.size() > base + 1) lat = k;
    end
    check("hold_release_lat", 32'(lat >= 1 && lat <= 2), 32'd1);
    wait_done(4, "hold_done_timeout");
    check_frame(base, "hold");

    // Reset mid-frame aborts at once; the next digest restarts from byte 0.
    base = chars.size();
    send_digest(abc_digest);
    wait_chars(base + 5, "rst_chars_timeout");
    rst = 1'b1;
    #1;
    check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("midrst_no_tx", 32'(chars.size() - base), 32'd5);
    base = chars.size();
    send_digest(abc_digest);
    wait_done(5, "rst2_done_timeout");
    check("rst2_first", 32'(char_at(base)), 32'(exp_frame[0]));
    check_frame(base, "rst2");

    repeat (5) @(negedge clk);
    check("done_total", 32'(done_cnt), 32'd5);
    check("protocol", 32'(prot_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
